// File: rtl/game_pkg.sv
// Shared definitions for the round_sequencer reaction game.
// Holds the FSM state encoding, the LFSR seed and the LFSR tap mask.
// No ports; imported with `import game_pkg::*;`.
package game_pkg;

    // Encoding is kept stable because state_dbg exposes these values.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SWEEP   = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Taps 8,6,5,4 (1-based), mapped onto register bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/tick_divider.sv
// Step timer for the round sequencer.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, counter to 0
//   clr  - synchronous restart: the counter is 0 on the following cycle
//   tick - high for one cycle when the counter reaches TICK_DIV-1
// With clr pulsed on a state change, the new state sees its first tick
// exactly TICK_DIV cycles after entry.
module tick_divider #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer for a light-sweep reaction game.
// Each round: lights go dark for one step (ARM), then a single light sweeps
// from position 0 to NLIGHTS-1, one step per TICK_DIV cycles (SWEEP). A key
// press ends the sweep and holds the board dark for two cycles (RESOLVE).
// The external score keeper sees the same key and reports add1/add2/sub2.
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   start               - pulse, begins a game from IDLE or DONE
//   key                 - pulse, player press (first press in a sweep counts)
//   add1, add2, sub2    - score-event pulses, applied only while busy
//   lights              - one-hot sweep position (0 outside SWEEP)
//   OlightOn            - sweep is on the target light
//   lastlightOn         - sweep is on the light after the target
//   score, round        - running score and completed rounds
//   busy, done, win     - game running / game over / game over with score>=WIN_SCORE
//   state_dbg           - current FSM state (game_pkg::state_t encoding)
// Handshake: every input is a single-cycle pulse sampled on the rising edge;
// there is no backpressure and nothing is queued, so a pulse in a state that
// does not use it is simply dropped.
module round_sequencer
    import game_pkg::*;
#(
    parameter int NLIGHTS   = 8,
    parameter int TICK_DIV  = 25000000,
    parameter int ROUNDS    = 16,
    parameter int SCORE_W   = 8,
    parameter int WIN_SCORE = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       key,
    input  logic                       add1,
    input  logic                       add2,
    input  logic                       sub2,
    output logic [NLIGHTS-1:0]         lights,
    output logic                       OlightOn,
    output logic                       lastlightOn,
    output logic [SCORE_W-1:0]         score,
    output logic [$clog2(ROUNDS):0]    round,
    output logic                       busy,
    output logic                       done,
    output logic                       win,
    output logic [2:0]                 state_dbg
);

    localparam int               LW       = $clog2(NLIGHTS);
    localparam int               RW       = $clog2(ROUNDS) + 1;
    localparam logic [LW-1:0]    POS_LAST = LW'(NLIGHTS - 1);
    localparam logic [LW-1:0]    POS_ALT  = LW'(NLIGHTS - 2);
    localparam logic [RW-1:0]    RND_LAST = RW'(ROUNDS - 1);
    localparam logic [SCORE_W-1:0] WIN_TH = SCORE_W'(WIN_SCORE);

    state_t             state, state_next;
    logic [LW-1:0]      pos;
    logic [LW-1:0]      target;
    logic [LW-1:0]      target_pick;
    logic [7:0]         lfsr;
    logic               res_cnt;
    logic               tick;
    logic               last_round;
    logic               start_game;
    logic               round_end;
    logic [SCORE_W-1:0] score_next;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_next != state),
        .tick (tick)
    );

    assign last_round = (round == RND_LAST);
    assign start_game = ((state == IDLE) || (state == DONE)) && start;

    // The last light is never a target, so the late window always exists.
    assign target_pick = (lfsr[LW-1:0] == POS_LAST) ? POS_ALT : lfsr[LW-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = ARM;
            ARM:        if (tick) state_next = SWEEP;
            SWEEP: begin
                // A press wins over a simultaneous end-of-sweep tick.
                if (key) begin
                    state_next = RESOLVE;
                end else if (tick && (pos == POS_LAST)) begin
                    state_next = last_round ? DONE : ARM;
                end
            end
            RESOLVE:    if (res_cnt) state_next = last_round ? DONE : ARM;
            default:    state_next = IDLE;
        endcase
    end

    assign round_end = ((state == SWEEP) && (state_next != SWEEP) && (state_next != RESOLVE))
                     || ((state == RESOLVE) && res_cnt);

    // Priority add2 > add1 > sub2; add saturates at all-ones, sub2 clamps at 0.
    always_comb begin
        logic [SCORE_W:0] sum;
        sum        = '0;
        score_next = score;
        if (add2) begin
            sum        = {1'b0, score} + (SCORE_W+1)'(2);
            score_next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end else if (add1) begin
            sum        = {1'b0, score} + (SCORE_W+1)'(1);
            score_next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end else if (sub2) begin
            score_next = (score < SCORE_W'(2)) ? '0 : score - SCORE_W'(2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pos     <= '0;
            target  <= '0;
            lfsr    <= LFSR_SEED;
            res_cnt <= 1'b0;
            score   <= '0;
            round   <= '0;
        end else begin
            state <= state_next;
            lfsr  <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};

            if ((state_next == ARM) && (state != ARM)) begin
                target <= target_pick;
            end

            // pos restarts on SWEEP entry, advances on ticks, freezes otherwise.
            if (state_next == SWEEP) begin
                if (state != SWEEP) begin
                    pos <= '0;
                end else if (tick) begin
                    pos <= pos + LW'(1);
                end
            end

            res_cnt <= (state == RESOLVE) ? ~res_cnt : 1'b0;

            if (start_game) begin
                round <= '0;
            end else if (round_end) begin
                round <= round + RW'(1);
            end

            if (start_game) begin
                score <= '0;
            end else if (busy) begin
                score <= score_next;
            end
        end
    end

    assign busy        = (state == ARM) || (state == SWEEP) || (state == RESOLVE);
    assign done        = (state == DONE);
    assign win         = done && (score >= WIN_TH);
    assign lights      = (state == SWEEP) ? (NLIGHTS'(1) << pos) : '0;
    assign OlightOn    = (state == SWEEP) && (pos == target);
    assign lastlightOn = (state == SWEEP) && (pos == target + LW'(1));
    assign state_dbg   = state;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer (NLIGHTS=8, TICK_DIV=4, ROUNDS=4,
// WIN_SCORE=6). Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, before the inputs are changed.
// With start sampled on the first edge after reset release, the LFSR still
// holds 8'hA5, so the target is 5.
module tb_round_sequencer;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, key = 1'b0, add1 = 1'b0, add2 = 1'b0, sub2 = 1'b0;
    logic [7:0] lights;
    logic       OlightOn, lastlightOn;
    logic [7:0] score;
    logic [2:0] round;
    logic       busy, done, win;
    logic [2:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    round_sequencer #(
        .NLIGHTS(8), .TICK_DIV(4), .ROUNDS(4), .SCORE_W(8), .WIN_SCORE(6)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key(key),
        .add1(add1), .add2(add2), .sub2(sub2),
        .lights(lights), .OlightOn(OlightOn), .lastlightOn(lastlightOn),
        .score(score), .round(round), .busy(busy), .done(done), .win(win),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset state ----
        ticks(2);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_lights", 32'(lights), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_win", 32'(win), 0);
        check("rst_score", 32'(score), 0);
        check("rst_round", 32'(round), 0);

        // ---- game 1, round 1: start (add2 ignored in IDLE), hit on target ----
        rst = 1'b0; start = 1'b1; add2 = 1'b1;
        tick();
        start = 1'b0; add2 = 1'b0;
        check("g1_arm_state", 32'(state_dbg), 32'(ARM));
        check("g1_idle_add2_ignored", 32'(score), 0);
        check("g1_arm_lights", 32'(lights), 0);
        check("g1_arm_busy", 32'(busy), 1);
        ticks(20);
        check("g1_pos4_lights", 32'(lights), 16);
        check("g1_pos4_olight", 32'(OlightOn), 0);
        ticks(4);
        check("g1_pos5_lights", 32'(lights), 32);
        check("g1_pos5_olight", 32'(OlightOn), 1);
        key = 1'b1;
        tick();
        key = 1'b0;
        check("g1_resolve_state", 32'(state_dbg), 32'(RESOLVE));
        check("g1_resolve_lights", 32'(lights), 0);
        check("g1_resolve_olight", 32'(OlightOn), 0);
        key = 1'b1; add2 = 1'b1;
        tick();
        key = 1'b0; add2 = 1'b0;
        check("g1_add2_score", 32'(score), 2);
        check("g1_resolve2_state", 32'(state_dbg), 32'(RESOLVE));
        tick();
        check("g1_r1_state", 32'(state_dbg), 32'(ARM));
        check("g1_r1_round", 32'(round), 1);
        check("g1_r1_score", 32'(score), 2);

        // ---- round 2: add2 during ARM, then a full sweep with no key ----
        add2 = 1'b1;
        tick();
        add2 = 1'b0;
        check("g1_arm_add2", 32'(score), 4);
        ticks(34);
        check("g1_miss_pos7", 32'(lights), 128);
        check("g1_miss_round_before", 32'(round), 1);
        tick();
        check("g1_miss_lights", 32'(lights), 0);
        check("g1_miss_round", 32'(round), 2);
        check("g1_miss_score", 32'(score), 4);
        check("g1_miss_state", 32'(state_dbg), 32'(ARM));

        // ---- round 3: press at pos 0 ----
        ticks(4);
        check("g1_r3_sweep_lights", 32'(lights), 1);
        key = 1'b1; tick(); key = 1'b0;
        add2 = 1'b1; tick(); add2 = 1'b0;
        check("g1_r3_score", 32'(score), 6);
        tick();
        check("g1_r3_round", 32'(round), 3);
        check("g1_r3_win_not_done", 32'(win), 0);

        // ---- round 4: last round ends the game ----
        ticks(4);
        key = 1'b1; tick(); key = 1'b0;
        add2 = 1'b1; tick(); add2 = 1'b0;
        tick();
        check("g1_done_state", 32'(state_dbg), 32'(DONE));
        check("g1_done", 32'(done), 1);
        check("g1_win", 32'(win), 1);
        check("g1_busy", 32'(busy), 0);
        check("g1_final_score", 32'(score), 8);
        check("g1_final_round", 32'(round), 4);
        check("g1_done_lights", 32'(lights), 0);
        add1 = 1'b1; tick(); add1 = 1'b0;
        check("g1_done_add1_ignored", 32'(score), 8);

        // ---- game 2: restart from DONE, score arithmetic ----
        start = 1'b1; tick(); start = 1'b0;
        check("g2_state", 32'(state_dbg), 32'(ARM));
        check("g2_score_clr", 32'(score), 0);
        check("g2_round_clr", 32'(round), 0);
        check("g2_done_clr", 32'(done), 0);
        add1 = 1'b1; tick(); add1 = 1'b0;
        check("g2_add1", 32'(score), 1);
        sub2 = 1'b1; tick(); sub2 = 1'b0;
        check("g2_sub2_from1", 32'(score), 0);
        sub2 = 1'b1; tick(); sub2 = 1'b0;
        check("g2_sub2_from0", 32'(score), 0);
        add1 = 1'b1; add2 = 1'b1; tick(); add1 = 1'b0; add2 = 1'b0;
        check("g2_add1_add2", 32'(score), 2);
        add1 = 1'b1; sub2 = 1'b1; tick(); add1 = 1'b0; sub2 = 1'b0;
        check("g2_add1_sub2", 32'(score), 3);
        add2 = 1'b1; sub2 = 1'b1; tick(); add2 = 1'b0; sub2 = 1'b0;
        check("g2_add2_sub2", 32'(score), 5);
        add2 = 1'b1; ticks(125); add2 = 1'b0;
        check("g2_reach_255", 32'(score), 255);
        add2 = 1'b1; tick(); add2 = 1'b0;
        check("g2_add2_sat", 32'(score), 255);
        add1 = 1'b1; tick(); add1 = 1'b0;
        check("g2_add1_sat", 32'(score), 255);
        start = 1'b1; tick(); start = 1'b0;
        check("g2_start_busy_score", 32'(score), 255);
        check("g2_start_busy_state", 32'(state_dbg), 32'(SWEEP));
        check("g2_start_busy_round", 32'(round), 3);
        check("g2_pos5_lights", 32'(lights), 32);

        // ---- asynchronous reset in the middle of a sweep ----
        #2 rst = 1'b1;
        #1;
        check("mid_rst_lights", 32'(lights), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_score", 32'(score), 0);
        check("mid_rst_round", 32'(round), 0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));

        // ---- replay after reset: same target as from power-up ----
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("g3_state", 32'(state_dbg), 32'(ARM));
        ticks(24);
        check("g3_pos5_olight", 32'(OlightOn), 1);
        check("g3_pos5_late", 32'(lastlightOn), 0);
        ticks(4);
        check("g3_pos6_lights", 32'(lights), 64);
        check("g3_pos6_olight", 32'(OlightOn), 0);
        check("g3_pos6_late", 32'(lastlightOn), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
